// File: rtl/mips_run_controller.sv
// mips_run_controller
// Sequences a single program run of the single-cycle MIPS32 core. It streams
// program words into instruction memory, holds the core in reset for one
// priming cycle, lets the core run, and stops on halt, timeout or fault.
// The status flags and counters stay visible after the run finishes.

module mips_run_controller #(
  parameter int IMEM_AW = 7,
  parameter int CYCLE_W = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [31:0]        load_data,
  input  logic               load_last,
  output logic               imem_wen,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  input  logic [31:0]        core_raddr,
  input  logic               core_halted,
  output logic               core_reset,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output logic               fault,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [IMEM_AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRIME = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The last legal word index. Accepting a non-final word at this index
  // means the program does not fit in imem.
  localparam logic [IMEM_AW:0]   WORDS_MAX   = (IMEM_AW+1)'((2 ** IMEM_AW) - 1);
  localparam logic [IMEM_AW:0]   WORDS_ONE   = (IMEM_AW+1)'(1);
  // Fetches at or beyond this word address fall outside imem.
  localparam logic [31:0]        IMEM_WORDS  = 32'(2 ** IMEM_AW);
  localparam logic [CYCLE_W-1:0] CYCLE_ONE   = CYCLE_W'(1);
  localparam logic [CYCLE_W-1:0] CYCLE_ZERO  = CYCLE_W'(0);
  localparam logic [CYCLE_W-1:0] TIMEOUT_M1  = CYCLE_W'(TIMEOUT - 1);
  localparam logic [CYCLE_W-1:0] TIMEOUT_VAL = CYCLE_W'(TIMEOUT);

  state_t             state_r;
  state_t             state_s;
  logic [IMEM_AW:0]   words_loaded_r;
  logic [IMEM_AW:0]   words_loaded_s;
  logic [CYCLE_W-1:0] cycle_count_r;
  logic [CYCLE_W-1:0] cycle_count_s;
  logic               timed_out_r;
  logic               timed_out_s;
  logic               fault_r;
  logic               fault_s;
  logic               core_reset_r;
  logic               busy_r;
  logic               done_r;
  logic               load_ready_s;
  logic               accept_s;
  logic               raddr_oor_s;

  // Load handshake and imem write port. These are combinational so that a
  // word can be written in the same cycle it is accepted.
  always_comb begin
    load_ready_s = (state_r == ST_LOAD);
    accept_s     = load_ready_s & load_valid;
    raddr_oor_s  = (core_raddr >= IMEM_WORDS);
  end

  assign load_ready = load_ready_s;
  assign imem_wen   = accept_s;
  assign imem_waddr = words_loaded_r[IMEM_AW-1:0];
  assign imem_wdata = load_data;

  // Next-state logic and next values for the counters and status flags.
  always_comb begin
    state_s        = state_r;
    words_loaded_s = words_loaded_r;
    cycle_count_s  = cycle_count_r;
    timed_out_s    = timed_out_r;
    fault_s        = fault_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s        = ST_LOAD;
          words_loaded_s = '0;
          cycle_count_s  = CYCLE_ZERO;
          timed_out_s    = 1'b0;
          fault_s        = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          words_loaded_s = words_loaded_r + WORDS_ONE;
          if (load_last) begin
            state_s = ST_PRIME;
          end else if (words_loaded_r == WORDS_MAX) begin
            fault_s = 1'b1;
            state_s = ST_DONE;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_PRIME: begin
        cycle_count_s = CYCLE_ZERO;
        state_s       = ST_RUN;
      end
      ST_RUN: begin
        // Halt takes priority over both the range fault and the timeout.
        if (core_halted) begin
          state_s = ST_DONE;
        end else if (raddr_oor_s) begin
          fault_s = 1'b1;
          state_s = ST_DONE;
        end else if (cycle_count_r == TIMEOUT_M1) begin
          cycle_count_s = TIMEOUT_VAL;
          timed_out_s   = 1'b1;
          state_s       = ST_DONE;
        end else begin
          cycle_count_s = cycle_count_r + CYCLE_ONE;
          state_s       = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs. The state-derived outputs are
  // computed from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      words_loaded_r <= '0;
      cycle_count_r  <= CYCLE_ZERO;
      timed_out_r    <= 1'b0;
      fault_r        <= 1'b0;
      core_reset_r   <= 1'b1;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      words_loaded_r <= words_loaded_s;
      cycle_count_r  <= cycle_count_s;
      timed_out_r    <= timed_out_s;
      fault_r        <= fault_s;
      core_reset_r   <= (state_s != ST_RUN);
      busy_r         <= (state_s == ST_LOAD) || (state_s == ST_PRIME) || (state_s == ST_RUN);
      done_r         <= (state_s == ST_DONE);
    end
  end

  assign core_reset   = core_reset_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign timed_out    = timed_out_r;
  assign fault        = fault_r;
  assign cycle_count  = cycle_count_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_mips_run_controller.sv
// tb_mips_run_controller
// Directed bench for mips_run_controller. dut_a (IMEM_AW=7, TIMEOUT=10) covers
// the load/run/halt/timeout/fault scenarios. dut_b (IMEM_AW=2) covers imem
// overflow. Both DUTs share the input stimulus.

module tb_mips_run_controller;

  localparam int AW_A = 7;
  localparam int AW_B = 2;
  localparam int CW   = 32;
  localparam int TO   = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          load_valid = 1'b0;
  logic [31:0]   load_data = 32'h0;
  logic          load_last = 1'b0;
  logic [31:0]   core_raddr;
  logic          core_halted;

  logic          a_load_ready, a_imem_wen, a_core_reset, a_busy, a_done, a_timed_out, a_fault;
  logic [AW_A-1:0] a_imem_waddr;
  logic [31:0]   a_imem_wdata;
  logic [CW-1:0] a_cycle_count;
  logic [AW_A:0] a_words_loaded;

  logic          b_load_ready, b_imem_wen, b_core_reset, b_busy, b_done, b_timed_out, b_fault;
  logic [AW_B-1:0] b_imem_waddr;
  logic [31:0]   b_imem_wdata;
  logic [CW-1:0] b_cycle_count;
  logic [AW_B:0] b_words_loaded;

  int checks   = 0;
  int failures = 0;

  mips_run_controller #(.IMEM_AW(AW_A), .CYCLE_W(CW), .TIMEOUT(TO)) dut_a (
    .clock(clock), .reset(reset), .start(start),
    .load_valid(load_valid), .load_ready(a_load_ready), .load_data(load_data), .load_last(load_last),
    .imem_wen(a_imem_wen), .imem_waddr(a_imem_waddr), .imem_wdata(a_imem_wdata),
    .core_raddr(core_raddr), .core_halted(core_halted), .core_reset(a_core_reset),
    .busy(a_busy), .done(a_done), .timed_out(a_timed_out), .fault(a_fault),
    .cycle_count(a_cycle_count), .words_loaded(a_words_loaded)
  );

  mips_run_controller #(.IMEM_AW(AW_B), .CYCLE_W(CW), .TIMEOUT(TO)) dut_b (
    .clock(clock), .reset(reset), .start(start),
    .load_valid(load_valid), .load_ready(b_load_ready), .load_data(load_data), .load_last(load_last),
    .imem_wen(b_imem_wen), .imem_waddr(b_imem_waddr), .imem_wdata(b_imem_wdata),
    .core_raddr(core_raddr), .core_halted(core_halted), .core_reset(b_core_reset),
    .busy(b_busy), .done(b_done), .timed_out(b_timed_out), .fault(b_fault),
    .cycle_count(b_cycle_count), .words_loaded(b_words_loaded)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Core model: count cycles out of reset. Halt after halt_after cycles, and
  // optionally fetch out of range on the second RUN cycle.
  int   halt_after = 1000;
  logic fault_inj  = 1'b0;
  int   run_cnt    = 0;
  always @(posedge clock) run_cnt <= a_core_reset ? 0 : run_cnt + 1;
  assign core_halted = (run_cnt >= halt_after);
  assign core_raddr  = (fault_inj && run_cnt == 1) ? 32'd128 : 32'(run_cnt);

  // imem models and write/run counters for both DUTs.
  logic [31:0] mem_a [0:(2**AW_A)-1];
  logic [31:0] mem_b [0:(2**AW_B)-1];
  int wr_a  = 0;
  int wr_b  = 0;
  int b_run = 0;
  always @(posedge clock) begin
    if (a_imem_wen) begin
      mem_a[a_imem_waddr] <= a_imem_wdata;
      wr_a <= wr_a + 1;
    end
    if (b_imem_wen) begin
      mem_b[b_imem_waddr] <= b_imem_wdata;
      wr_b <= wr_b + 1;
    end
    if (!b_core_reset) b_run <= b_run + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input bit gap);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(posedge clock);
    @(negedge clock);
    load_valid = 1'b0;
    load_last  = 1'b0;
    if (gap) @(negedge clock);
  endtask

  task automatic wait_done(input bit use_b, input string tag);
    int n = 0;
    while (!(use_b ? b_done : a_done) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done_bound"}, 64'(use_b ? b_done : a_done), 64'd1);
  endtask

  // Four words, last on the fourth; core halts after 3 RUN cycles.
  task automatic run_t1(input string tag, input logic [31:0] base);
    int w0;
    halt_after = 3;
    fault_inj  = 1'b0;
    w0 = wr_a;
    pulse_start();
    check({tag, "_load_busy"}, 64'(a_busy), 64'd1);
    check({tag, "_load_ready"}, 64'(a_load_ready), 64'd1);
    for (int i = 0; i < 4; i++) send_word(base + 32'(i), (i == 3), 1'b0);
    check({tag, "_prime_core_reset"}, 64'(a_core_reset), 64'd1);
    check({tag, "_prime_ready"}, 64'(a_load_ready), 64'd0);
    @(negedge clock);
    check({tag, "_run_core_reset"}, 64'(a_core_reset), 64'd0);
    wait_done(1'b0, tag);
    check({tag, "_cycles"}, 64'(a_cycle_count), 64'd3);
    check({tag, "_words"}, 64'(a_words_loaded), 64'd4);
    check({tag, "_timed_out"}, 64'(a_timed_out), 64'd0);
    check({tag, "_fault"}, 64'(a_fault), 64'd0);
    check({tag, "_busy"}, 64'(a_busy), 64'd0);
    check({tag, "_done_core_reset"}, 64'(a_core_reset), 64'd1);
    check({tag, "_writes"}, 64'(wr_a - w0), 64'd4);
    for (int i = 0; i < 4; i++) check({tag, "_mem"}, 64'(mem_a[i]), 64'(base + 32'(i)));
  endtask

  initial begin
    int w0;
    do_reset();

    // Reset state.
    check("rst_core_reset", 64'(a_core_reset), 64'd1);
    check("rst_ready", 64'(a_load_ready), 64'd0);
    check("rst_wen", 64'(a_imem_wen), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_flags", 64'({a_timed_out, a_fault}), 64'd0);
    check("rst_cycles", 64'(a_cycle_count), 64'd0);
    check("rst_words", 64'(a_words_loaded), 64'd0);

    // T1: basic load and halt.
    run_t1("t1", 32'hA000_0000);

    // T2: the core never halts, so the run ends on TIMEOUT.
    halt_after = 1000;
    pulse_start();
    send_word(32'hC0DE_0000, 1'b1, 1'b0);
    wait_done(1'b0, "t2");
    check("t2_cycles", 64'(a_cycle_count), 64'd10);
    check("t2_timed_out", 64'(a_timed_out), 64'd1);
    check("t2_fault", 64'(a_fault), 64'd0);
    check("t2_core_reset", 64'(a_core_reset), 64'd1);

    // T4: load_valid toggles, and start is pulsed during LOAD and during RUN.
    halt_after = 5;
    w0 = wr_a;
    pulse_start();
    send_word(32'hB000_0000, 1'b0, 1'b1);
    pulse_start();
    send_word(32'hB000_0001, 1'b1, 1'b1);
    @(negedge clock);
    pulse_start();
    check("t4_run_busy", 64'(a_busy), 64'd1);
    wait_done(1'b0, "t4");
    check("t4_writes", 64'(wr_a - w0), 64'd2);
    check("t4_mem0", 64'(mem_a[0]), 64'h0B000_0000);
    check("t4_mem1", 64'(mem_a[1]), 64'h0B000_0001);
    check("t4_mem2_untouched", 64'(mem_a[2]), 64'h0A000_0002);
    check("t4_words", 64'(a_words_loaded), 64'd2);
    check("t4_cycles", 64'(a_cycle_count), 64'd5);

    // T5a: an out-of-range fetch on RUN cycle 2 faults the run.
    halt_after = 100;
    fault_inj  = 1'b1;
    pulse_start();
    send_word(32'hD000_0000, 1'b1, 1'b0);
    wait_done(1'b0, "t5a");
    check("t5a_fault", 64'(a_fault), 64'd1);
    check("t5a_cycles", 64'(a_cycle_count), 64'd1);
    check("t5a_timed_out", 64'(a_timed_out), 64'd0);

    // T5b: a halt in the same cycle as the bad fetch wins over the fault.
    halt_after = 1;
    pulse_start();
    send_word(32'hD000_0001, 1'b1, 1'b0);
    wait_done(1'b0, "t5b");
    check("t5b_fault", 64'(a_fault), 64'd0);
    check("t5b_cycles", 64'(a_cycle_count), 64'd1);
    fault_inj = 1'b0;

    // T6: reset asserted mid-RUN, followed by a clean rerun.
    halt_after = 100;
    pulse_start();
    send_word(32'hE000_0000, 1'b0, 1'b0);
    send_word(32'hE000_0001, 1'b1, 1'b0);
    repeat (5) @(negedge clock);
    check("t6_pre_cycles", 64'(a_cycle_count), 64'd4);
    reset = 1'b1;
    @(negedge clock);
    check("t6_rst_core_reset", 64'(a_core_reset), 64'd1);
    check("t6_rst_busy", 64'(a_busy), 64'd0);
    check("t6_rst_done", 64'(a_done), 64'd0);
    check("t6_rst_flags", 64'({a_timed_out, a_fault}), 64'd0);
    check("t6_rst_cycles", 64'(a_cycle_count), 64'd0);
    check("t6_rst_words", 64'(a_words_loaded), 64'd0);
    check("t6_rst_ready", 64'(a_load_ready), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    run_t1("t6", 32'h5000_0000);

    // T3: dut_b overflows imem because no word carries load_last.
    do_reset();
    w0 = wr_b;
    begin
      int r0;
      r0 = b_run;
      pulse_start();
      for (int i = 0; i < 4; i++) send_word(32'hF000_0000 + 32'(i), 1'b0, 1'b0);
      check("t3_done", 64'(b_done), 64'd1);
      check("t3_fault", 64'(b_fault), 64'd1);
      check("t3_words", 64'(b_words_loaded), 64'd4);
      check("t3_writes", 64'(wr_b - w0), 64'd4);
      check("t3_mem3", 64'(mem_b[3]), 64'h0F000_0003);
      check("t3_no_run", 64'(b_run - r0), 64'd0);
      check("t3_ready", 64'(b_load_ready), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
